// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control encodings: opcodes, FSM state numbering and datapath select codes.
// Used by both the multicycle controller and the single-cycle decoder.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SUBI  = 6'h0A;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_MULT  = 6'h18;
    localparam logic [5:0] OP_DIV   = 6'h1A;
    localparam logic [5:0] OP_NOT   = 6'h1C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_IEXEC  = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_MDWAIT = 4'd12,
        S_JR     = 4'd13
    } state_t;

    localparam logic [1:0] SRCB_REG = 2'b00, SRCB_FOUR = 2'b01, SRCB_SIMM = 2'b10, SRCB_SIMM4 = 2'b11;
    localparam logic [1:0] ALU_ADD  = 2'b00, ALU_SUB   = 2'b01, ALU_FUNCT = 2'b10, ALU_LUI = 2'b11;
    localparam logic [1:0] PC_ALU   = 2'b00, PC_ALUOUT = 2'b01, PC_JTGT = 2'b10, PC_RS = 2'b11;
    localparam logic [1:0] DST_RT   = 2'b00, DST_RD = 2'b01, DST_R31 = 2'b10;
    localparam logic [1:0] WB_ALU   = 2'b00, WB_MDR = 2'b01, WB_PC = 2'b10;

endpackage

// File: rtl/md_latency_counter.sv
// Down-counter that times the mult/div stall; loaded at decode, zero flag ends the wait.
module md_latency_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS controller: Moore FSM driving the shared memory/ALU datapath selects,
// with memory-ready stalls and a fixed-latency mult/div wait.
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 8,
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNE,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       HiLoWrite,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 1);

    state_t     state_q, state_d;
    logic [5:0] op_q, fn_q;
    logic       rdy, md_zero, md_load, md_dec, op_legal;
    logic       unused_ok;

    assign rdy       = MEM_WAIT_EN ? mem_ready : 1'b1;
    assign unused_ok = ^{zero, fn_q};
    assign state     = state_q;

    always_comb begin
        op_legal = 1'b1;
        case (opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_SUBI, OP_LUI,
            OP_J, OP_JAL, OP_MULT, OP_DIV, OP_NOT: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    assign md_load = (state_q == S_DECODE) && (opcode == OP_MULT || opcode == OP_DIV);
    assign md_dec  = (state_q == S_MDWAIT);

    md_latency_counter #(.CNT_W(CNT_W)) u_md_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (md_load),
        .load_val ((opcode == OP_MULT) ? MULT_LD : DIV_LD),
        .dec      (md_dec),
        .zero     (md_zero)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (rdy) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:                  state_d = (funct == FN_JR) ? S_JR : S_EXEC;
                    OP_NOT:                    state_d = S_EXEC;
                    OP_LW, OP_SW:              state_d = S_MEMADR;
                    OP_BEQ, OP_BNE:            state_d = S_BRANCH;
                    OP_ADDI, OP_SUBI, OP_LUI:  state_d = S_IEXEC;
                    OP_J, OP_JAL:              state_d = S_JUMP;
                    OP_MULT, OP_DIV:           state_d = S_MDWAIT;
                    default:                   state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (rdy) state_d = S_MEMWB;
            S_MEMWR:  if (rdy) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_IEXEC:  state_d = S_IWB;
            S_MDWAIT: if (md_zero) state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            fn_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
                fn_q <= funct;
            end
        end
    end

    // Moore decode; the whole block is forced quiet while reset is high.
    always_comb begin
        PCWrite = 1'b0; PCWriteCond = 1'b0; BranchNE = 1'b0; IorD = 1'b0;
        IRWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0;
        ALUSrcA = 1'b0; HiLoWrite = 1'b0; instr_done = 1'b0; illegal_op = 1'b0;
        ALUSrcB = SRCB_REG; ALUOp = ALU_ADD; PCSource = PC_ALU;
        RegDst = DST_RT; MemtoReg = WB_ALU;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1; ALUSrcB = SRCB_FOUR;
                IRWrite = rdy;  PCWrite = rdy;
            end
            S_DECODE: begin
                ALUSrcB    = SRCB_SIMM4;
                illegal_op = !op_legal;
                instr_done = !op_legal;
            end
            S_MEMADR: begin ALUSrcA = 1'b1; ALUSrcB = SRCB_SIMM; end
            S_MEMRD:  begin MemRead = 1'b1; IorD = 1'b1; end
            S_MEMWB:  begin RegWrite = 1'b1; MemtoReg = WB_MDR; instr_done = 1'b1; end
            S_MEMWR:  begin MemWrite = 1'b1; IorD = 1'b1; instr_done = rdy; end
            S_EXEC:   begin ALUSrcA = 1'b1; ALUOp = ALU_FUNCT; end
            S_ALUWB:  begin RegWrite = 1'b1; RegDst = DST_RD; instr_done = 1'b1; end
            S_IEXEC: begin
                ALUSrcA = 1'b1; ALUSrcB = SRCB_SIMM;
                ALUOp   = (op_q == OP_LUI) ? ALU_LUI : (op_q == OP_SUBI) ? ALU_SUB : ALU_ADD;
            end
            S_IWB:    begin RegWrite = 1'b1; instr_done = 1'b1; end
            S_BRANCH: begin
                ALUSrcA = 1'b1; ALUOp = ALU_SUB; PCWriteCond = 1'b1;
                PCSource = PC_ALUOUT; BranchNE = (op_q == OP_BNE); instr_done = 1'b1;
            end
            S_JUMP: begin
                PCWrite = 1'b1; PCSource = PC_JTGT; instr_done = 1'b1;
                if (op_q == OP_JAL) begin
                    RegWrite = 1'b1; RegDst = DST_R31; MemtoReg = WB_PC;
                end
            end
            S_JR:     begin PCWrite = 1'b1; PCSource = PC_RS; instr_done = 1'b1; end
            S_MDWAIT: begin
                ALUSrcA = 1'b1; ALUOp = ALU_FUNCT;
                HiLoWrite = md_zero; instr_done = md_zero;
            end
            default: ;
        endcase
        if (reset) begin
            PCWrite = 1'b0; PCWriteCond = 1'b0; BranchNE = 1'b0; IorD = 1'b0;
            IRWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0;
            ALUSrcA = 1'b0; HiLoWrite = 1'b0; instr_done = 1'b0; illegal_op = 1'b0;
            ALUSrcB = 2'b00; ALUOp = 2'b00; PCSource = 2'b00; RegDst = 2'b00; MemtoReg = 2'b00;
        end
    end

endmodule
